// File: rtl/frame_sync_pkg.sv
// Shared frame-sync definitions: default sync word, reset level, state encoding
// and the Hamming-distance helper used by the correlator.
package frame_sync_pkg;

  localparam int unsigned SYNC_W = 16;
  localparam int unsigned DIST_W = 5;

  localparam logic [SYNC_W-1:0] SYNC_WORD_DEFAULT = 16'hEB90;
  localparam logic              RST_ACTIVE        = 1'b0;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_FLY     = 2'd3
  } state_e;

  function automatic logic [DIST_W-1:0] hamming16(input logic [SYNC_W-1:0] a,
                                                  input logic [SYNC_W-1:0] b);
    logic [SYNC_W-1:0] x;
    logic [DIST_W-1:0] n;
    x = a ^ b;
    n = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      n = n + DIST_W'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/frame_sync_correlator.sv
// Combinational sync-word correlator: bit distance between pattern and word,
// flagged as a match when the distance does not exceed THRESH.
module sync_correlator
  import frame_sync_pkg::*;
#(
  parameter int unsigned THRESH = 0
) (
  input  logic [15:0] pattern_i,
  input  logic [15:0] word_i,
  output logic [4:0]  dist_c,
  output logic        match_c
);

  always_comb begin
    dist_c  = hamming16(pattern_i, word_i);
    match_c = (32'(dist_c) <= THRESH);
  end

endmodule

// File: rtl/frame_sync.sv
// Serial frame synchroniser: hunts for the sync word, deserialises payload bytes,
// verifies the sync word of every following frame and flywheels through misses.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int unsigned SYNC_THRESH   = 0,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned MISS_LIMIT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_i,
  input  logic       data_valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       locked_o,
  output logic       sync_err_o
);

  localparam int unsigned PAYLOAD_BITS = PAYLOAD_BYTES * 8;
  localparam int unsigned CNT_W  = $clog2((PAYLOAD_BITS > SYNC_W) ? PAYLOAD_BITS : SYNC_W);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   hist_q, hist_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]          byte_sr_q, byte_sr_d;
  logic [7:0]          byte_q, byte_d;
  logic                byte_valid_q, byte_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_end_q, frame_end_d;
  logic                locked_q, locked_d;
  logic                sync_err_q, sync_err_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  logic [SYNC_W-1:0]   hist_shift;
  logic [MISS_W-1:0]   miss_inc;
  logic [DIST_W-1:0]   corr_dist;
  logic                corr_match;

  // Correlate the history including the bit arriving this cycle.
  assign hist_shift = {hist_q[SYNC_W-2:0], data_i};

  sync_correlator #(
    .THRESH (SYNC_THRESH)
  ) u_corr (
    .pattern_i (SYNC_WORD),
    .word_i    (hist_shift),
    .dist_c    (corr_dist),
    .match_c   (corr_match)
  );

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    bit_cnt_d     = bit_cnt_q;
    byte_sr_d     = byte_sr_q;
    byte_d        = byte_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    locked_d      = locked_q;
    sync_err_d    = 1'b0;
    miss_d        = miss_q;
    miss_inc      = (miss_q == MISS_W'(MISS_LIMIT)) ? miss_q : miss_q + MISS_W'(1);

    if (data_valid_i) begin
      hist_d = hist_shift;
      case (state_q)
        ST_HUNT: begin
          if (corr_match) begin
            state_d   = ST_PAYLOAD;
            bit_cnt_d = '0;
          end
        end
        ST_PAYLOAD, ST_FLY: begin
          byte_sr_d = {byte_sr_q[6:0], data_i};
          if (bit_cnt_q[2:0] == 3'd7) begin
            byte_d        = {byte_sr_q[6:0], data_i};
            byte_valid_d  = 1'b1;
            frame_start_d = (bit_cnt_q == CNT_W'(7));
            frame_end_d   = (bit_cnt_q == CNT_W'(PAYLOAD_BITS - 1));
          end
          if (bit_cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
            state_d   = ST_CHECK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (bit_cnt_q == CNT_W'(SYNC_W - 1)) begin
            bit_cnt_d = '0;
            if (corr_match) begin
              locked_d = 1'b1;
              miss_d   = '0;
              state_d  = ST_PAYLOAD;
            end else begin
              sync_err_d = 1'b1;
              if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                locked_d = 1'b0;
                miss_d   = '0;
                state_d  = ST_HUNT;
              end else begin
                miss_d  = miss_inc;
                state_d = ST_FLY;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q       <= ST_HUNT;
      hist_q        <= '0;
      bit_cnt_q     <= '0;
      byte_sr_q     <= '0;
      byte_q        <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      miss_q        <= '0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_sr_q     <= byte_sr_d;
      byte_q        <= byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      miss_q        <= miss_d;
    end
  end

  // A reported match must always be within the configured threshold.
  assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
                   corr_match |-> (32'(corr_dist) <= SYNC_THRESH));

  assign byte_o        = byte_q;
  assign byte_valid_o  = byte_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign locked_o      = locked_q;
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: default instance plus a SYNC_THRESH=1 instance.
module tb_frame_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_i, data_valid_i;
  logic       data2_i, data2_valid_i;
  logic [7:0] byte_o, byte2_o;
  logic       byte_valid_o, frame_start_o, frame_end_o, locked_o, sync_err_o;
  logic       byte_valid2_o, frame_start2_o, frame_end2_o, locked2_o, sync_err2_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] q1[$];
  logic [9:0] q2[$];
  int err1 = 0, err2 = 0, run1 = 0, max_run1 = 0;
  logic sel    = 1'b0;
  logic gap_en = 1'b0;

  always #5 clk = ~clk;

  frame_sync u_dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o),
    .locked_o      (locked_o),
    .sync_err_o    (sync_err_o)
  );

  frame_sync #(.SYNC_THRESH(1)) u_dut_thr (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data2_i),
    .data_valid_i  (data2_valid_i),
    .byte_o        (byte2_o),
    .byte_valid_o  (byte_valid2_o),
    .frame_start_o (frame_start2_o),
    .frame_end_o   (frame_end2_o),
    .locked_o      (locked2_o),
    .sync_err_o    (sync_err2_o)
  );

  always @(negedge clk) begin
    if (byte_valid_o) begin
      q1.push_back({frame_end_o, frame_start_o, byte_o});
      run1 = run1 + 1;
      if (run1 > max_run1) max_run1 = run1;
    end else begin
      run1 = 0;
    end
    if (sync_err_o) err1 = err1 + 1;
    if (byte_valid2_o) q2.push_back({frame_end2_o, frame_start2_o, byte2_o});
    if (sync_err2_o) err2 = err2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (sel) begin
      data2_i       = b;
      data2_valid_i = 1'b1;
    end else begin
      data_i       = b;
      data_valid_i = 1'b1;
    end
    @(negedge clk);
    data_valid_i  = 1'b0;
    data2_valid_i = 1'b0;
    if (gap_en) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_payload(input logic [31:0] p);
    send_byte(p[31:24]);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  // Checks the four strobed bytes recorded since index base, with start/end flags.
  task automatic chk_frame(input string tag, input logic which, input int base,
                           input logic [31:0] p);
    logic [9:0] exp_e;
    logic [9:0] got_e;
    int         sz;
    sz = which ? q2.size() : q1.size();
    chk({tag, "_count"}, 32'(sz - base), 32'd4);
    if (sz - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_e = {(i == 3) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, p[31 - 8*i -: 8]};
        got_e = which ? q2[base + i] : q1[base + i];
        chk($sformatf("%s_b%0d", tag, i), 32'(got_e), 32'(exp_e));
      end
    end
  endtask

  initial begin
    int base;
    int e0;
    rst           = 1'b0;
    data_i        = 1'b0;
    data_valid_i  = 1'b0;
    data2_i       = 1'b0;
    data2_valid_i = 1'b0;
    idle(3);
    chk("rst_byte",   32'(byte_o), 32'h00);
    chk("rst_bvalid", 32'(byte_valid_o), 32'd0);
    chk("rst_start",  32'(frame_start_o), 32'd0);
    chk("rst_end",    32'(frame_end_o), 32'd0);
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_err",    32'(sync_err_o), 32'd0);
    rst = 1'b1;
    idle(1);

    // Acquire: first sync, one frame, second sync locks.
    base = q1.size();
    e0   = err1;
    send_word(16'hEB90);
    send_payload(32'hA53CFF00);
    idle(2);
    chk_frame("s1", 1'b0, base, 32'hA53CFF00);
    chk("s1_not_locked", 32'(locked_o), 32'd0);
    send_word(16'hEB90);
    idle(2);
    chk("s1_locked", 32'(locked_o), 32'd1);
    chk("s1_no_err", 32'(err1 - e0), 32'd0);

    // Single corrupted sync: flywheel, then good sync clears the miss count.
    e0 = err1;
    send_payload(32'h11223344);
    send_word(16'hEB91);
    idle(2);
    chk("s2_err1",  32'(err1 - e0), 32'd1);
    chk("s2_lock1", 32'(locked_o), 32'd1);
    base = q1.size();
    send_payload(32'h55667788);
    idle(2);
    chk_frame("s2_fly", 1'b0, base, 32'h55667788);
    send_word(16'hEB90);
    idle(2);
    chk("s2_err_good", 32'(err1 - e0), 32'd1);
    send_payload(32'h01020304);
    send_word(16'h1234);
    send_payload(32'h05060708);
    send_word(16'h1234);
    idle(2);
    chk("s2_err3",      32'(err1 - e0), 32'd3);
    chk("s2_kept_lock", 32'(locked_o), 32'd1);
    send_payload(32'h090A0B0C);
    send_word(16'hEB90);
    idle(2);
    chk("s2_relock", 32'(locked_o), 32'd1);

    // Three consecutive misses drop lock and return to hunting.
    e0 = err1;
    send_payload(32'h10203040);
    send_word(16'h1234);
    send_payload(32'h50607080);
    send_word(16'h1234);
    send_payload(32'h90A0B0C0);
    for (int i = 15; i >= 1; i--) send_bit(1'(32'h1234 >> i));
    chk("s3_pre_drop", 32'(locked_o), 32'd1);
    send_bit(1'b0);
    chk("s3_drop",      32'(locked_o), 32'd0);
    chk("s3_err_pulse", 32'(sync_err_o), 32'd1);
    idle(2);
    chk("s3_err3", 32'(err1 - e0), 32'd3);
    base = q1.size();
    send_payload(32'h00000000);
    idle(2);
    chk("s3_hunt_silent", 32'(q1.size() - base), 32'd0);
    base = q1.size();
    send_word(16'hEB90);
    send_payload(32'hA1B2C3D4);
    idle(2);
    chk_frame("s3_reacq", 1'b0, base, 32'hA1B2C3D4);
    chk("s3_not_yet_locked", 32'(locked_o), 32'd0);
    send_word(16'hEB90);
    idle(2);
    chk("s3_relocked", 32'(locked_o), 32'd1);

    // Locked link with random gaps between valid bits.
    base   = q1.size();
    gap_en = 1'b1;
    send_payload(32'h5AC30FF0);
    send_word(16'hEB90);
    gap_en = 1'b0;
    idle(2);
    chk_frame("s4_gaps", 1'b0, base, 32'h5AC30FF0);
    chk("s4_strobe_width", 32'(max_run1), 32'd1);
    chk("s4_locked", 32'(locked_o), 32'd1);

    // Reset mid-frame after three payload bits.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    base = q1.size();
    rst  = 1'b0;
    idle(1);
    chk("s5_rst_byte",   32'(byte_o), 32'h00);
    chk("s5_rst_bvalid", 32'(byte_valid_o), 32'd0);
    chk("s5_rst_locked", 32'(locked_o), 32'd0);
    idle(1);
    rst = 1'b1;
    idle(2);
    chk("s5_no_strobe", 32'(q1.size() - base), 32'd0);
    chk("s5_unlocked",  32'(locked_o), 32'd0);
    base = q1.size();
    send_word(16'hEB90);
    send_payload(32'h12345678);
    idle(2);
    chk_frame("s5_fresh", 1'b0, base, 32'h12345678);
    send_word(16'hEB90);
    idle(2);
    chk("s5_locked", 32'(locked_o), 32'd1);

    // Threshold-1 instance: one bit error tolerated, more rejected.
    sel  = 1'b1;
    base = q2.size();
    e0   = err2;
    send_word(16'hEB98);
    send_payload(32'h01020304);
    idle(2);
    chk_frame("s6_hunt_d1", 1'b1, base, 32'h01020304);
    chk("s6_not_locked", 32'(locked2_o), 32'd0);
    send_word(16'hEB90);
    idle(2);
    chk("s6_locked", 32'(locked2_o), 32'd1);
    send_payload(32'hCAFEF00D);
    send_word(16'hEB9B);
    idle(2);
    chk("s6_check_reject", 32'(err2 - e0), 32'd1);
    chk("s6_still_locked", 32'(locked2_o), 32'd1);
    send_payload(32'hDEADBEEF);
    send_word(16'hEB98);
    idle(2);
    chk("s6_check_accept", 32'(err2 - e0), 32'd1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    base = q2.size();
    send_word(16'hEB9B);
    send_payload(32'h00000000);
    idle(2);
    chk("s6_hunt_reject", 32'(q2.size() - base), 32'd0);
    chk("s6_hunt_unlocked", 32'(locked2_o), 32'd0);
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
